fifo_sync_param: RTL

Parametrised single-clock synchronous FIFO. It is the next generation of the 8-bit push/pop FIFO and adds configurable width and depth, an occupancy count, almost-full and almost-empty thresholds, and a first-word-fall-through (FWFT) read mode. It also adds sticky error status. It sits between a producer and a consumer inside one clock domain and is driven by a Go2UVM interface/clocking-block bench.

---
 rtl/fifo_sync_param.sv | 112 +++++++++++
 1 files changed

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, almost flags, sticky errors, registered or FWFT read.
// Read latency 1 cycle (FWFT=0) or head always visible (FWFT=1); push is rejected at full unless a pop is accepted in the same cycle.
module fifo_sync_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     err_clr,
  output logic [DATA_W-1:0]        data_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_err_on_full,
  output logic                     pop_err_on_empty,
  output logic [1:0]               err_sticky
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (AF_THRESH < 1) || (AF_THRESH > DEPTH) ||
      (AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_param
    $error("fifo_sync_param: illegal DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_err_q, push_err_d;
  logic              pop_err_q, pop_err_d;
  logic [1:0]        sticky_q, sticky_d;
  logic              push_acc, pop_acc;

  always_comb begin
    pop_acc  = pop && (count_q != '0);
    push_acc = push && ((count_q != CW'(DEPTH)) || pop_acc);

    rd_ptr_d = pop_acc  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;

    count_d = count_q;
    if (push_acc && !pop_acc)      count_d = count_q + CW'(1);
    else if (pop_acc && !push_acc) count_d = count_q - CW'(1);

    push_err_d = push && !push_acc;
    pop_err_d  = pop && !pop_acc;

    // A new error in the clearing cycle must survive the clear.
    sticky_d = err_clr ? 2'b00 : sticky_q;
    sticky_d = sticky_d | {push_err_d, pop_err_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      push_err_q <= 1'b0;
      pop_err_q  <= 1'b0;
      sticky_q   <= 2'b00;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      push_err_q <= push_err_d;
      pop_err_q  <= pop_err_d;
      sticky_q   <= sticky_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_acc) mem_q[wr_ptr_q] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  end else begin : g_reg_rd
    logic [DATA_W-1:0] data_out_q, data_out_d;

    always_comb begin
      data_out_d = pop_acc ? mem_q[rd_ptr_q] : data_out_q;
    end

    always_ff @(posedge clk) begin
      if (rst) data_out_q <= '0;
      else     data_out_q <= data_out_d;
    end

    assign data_out = data_out_q;
  end

  assign count            = count_q;
  assign empty            = (count_q == '0);
  assign full             = (count_q == CW'(DEPTH));
  assign almost_empty     = (count_q <= CW'(AE_THRESH));
  assign almost_full      = (count_q >= CW'(AF_THRESH));
  assign push_err_on_full = push_err_q;
  assign pop_err_on_empty = pop_err_q;
  assign err_sticky       = sticky_q;

endmodule
